// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states,
// error codes and the idle value driven on the debug write-data bus.
package imem_loader_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } loader_state_t;

    // err_code values
    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_VERIFY = 2'd1;
    localparam logic [1:0] ERR_RANGE  = 2'd2;
    localparam logic [1:0] ERR_ALIGN  = 2'd3;

    // RISC-V "addi x0, x0, 0": harmless value parked on the write-data bus
    localparam logic [31:0] NOP = 32'h0000_0013;

    // True when a byte address falls inside a memory of mem_words 32-bit words
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned mem_words);
        return ({2'b00, addr[31:2]} < 32'(mem_words));
    endfunction

endpackage

// File: rtl/imem_boot_loader.sv
// Boot-time loader: streams host words into the instruction memory through
// its debug port, reads each word back to verify it, and keeps the core's
// fetch stage held until a complete verified image is in place.
module imem_boot_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [10:0] word_count,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    output logic        mem_dbg_en,
    output logic [31:0] mem_dbg_addr,
    output logic [31:0] mem_dbg_data,
    output logic        mem_dbg_we,
    input  logic [31:0] mem_dbg_rdata,
    output logic        core_hold,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code,
    output logic [31:0] err_addr,
    output logic [10:0] words_loaded
);

    loader_state_t state_reg;
    logic [31:0]   cur_addr_reg;
    logic [10:0]   remaining_reg;
    logic [31:0]   word_reg;

    // The debug address simply follows the current word address; the memory
    // only acts on it while mem_dbg_en is high.
    assign mem_dbg_addr = cur_addr_reg;

    // Session FSM with all status/handshake outputs registered alongside the state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            cur_addr_reg  <= 32'd0;
            remaining_reg <= 11'd0;
            word_reg      <= 32'd0;
            s_ready       <= 1'b0;
            mem_dbg_en    <= 1'b0;
            mem_dbg_data  <= NOP;
            mem_dbg_we    <= 1'b0;
            core_hold     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_code      <= ERR_NONE;
            err_addr      <= 32'd0;
            words_loaded  <= 11'd0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        if (base_addr[1:0] != 2'b00) begin
                            state_reg <= ST_ERROR;
                            err_code  <= ERR_ALIGN;
                            err_addr  <= base_addr;
                            done      <= 1'b0;
                            core_hold <= 1'b1;
                        end else if (word_count == 11'd0) begin
                            // Empty image: nothing to write, release the core
                            state_reg    <= ST_DONE;
                            err_code     <= ERR_NONE;
                            words_loaded <= 11'd0;
                            done         <= 1'b1;
                            core_hold    <= 1'b0;
                        end else begin
                            state_reg     <= ST_LOAD;
                            cur_addr_reg  <= base_addr;
                            remaining_reg <= word_count;
                            words_loaded  <= 11'd0;
                            err_code      <= ERR_NONE;
                            s_ready       <= 1'b1;
                            mem_dbg_en    <= 1'b1;
                            busy          <= 1'b1;
                            done          <= 1'b0;
                            core_hold     <= 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    // s_ready is always high here, so s_valid alone is the handshake
                    if (s_valid) begin
                        s_ready <= 1'b0;
                        if (!addr_in_range(cur_addr_reg, MEM_WORDS)) begin
                            // Checked before every write so a wrapped address never aliases
                            state_reg  <= ST_ERROR;
                            err_code   <= ERR_RANGE;
                            err_addr   <= cur_addr_reg;
                            mem_dbg_en <= 1'b0;
                            busy       <= 1'b0;
                        end else begin
                            state_reg    <= ST_WRITE;
                            word_reg     <= s_data;
                            mem_dbg_data <= s_data;
                            mem_dbg_we   <= 1'b1;
                        end
                    end
                end

                ST_WRITE: begin
                    // Single-cycle write strobe; the memory commits at this edge
                    state_reg    <= ST_CHECK;
                    mem_dbg_we   <= 1'b0;
                    mem_dbg_data <= NOP;
                end

                ST_CHECK: begin
                    if (mem_dbg_rdata != word_reg) begin
                        state_reg  <= ST_ERROR;
                        err_code   <= ERR_VERIFY;
                        err_addr   <= cur_addr_reg;
                        mem_dbg_en <= 1'b0;
                        busy       <= 1'b0;
                    end else begin
                        words_loaded  <= words_loaded + 11'd1;
                        remaining_reg <= remaining_reg - 11'd1;
                        cur_addr_reg  <= cur_addr_reg + 32'd4;
                        if (remaining_reg == 11'd1) begin
                            state_reg  <= ST_DONE;
                            mem_dbg_en <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            core_hold  <= 1'b0;
                        end else begin
                            state_reg <= ST_LOAD;
                            s_ready   <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_reg  <= ST_IDLE;
                    s_ready    <= 1'b0;
                    mem_dbg_en <= 1'b0;
                    mem_dbg_we <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    core_hold  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader with a behavioural 1024-word
// instruction memory (combinational debug readback, write on clock edge).
module tb_imem_boot_loader;

    localparam logic [31:0] NOP_W = 32'h0000_0013;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] base_addr;
    logic [10:0] word_count;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        mem_dbg_en;
    logic [31:0] mem_dbg_addr;
    logic [31:0] mem_dbg_data;
    logic        mem_dbg_we;
    logic [31:0] mem_dbg_rdata;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;
    logic [31:0] err_addr;
    logic [10:0] words_loaded;

    // Memory model
    logic [31:0] mem [0:1023];
    int          write_count;
    logic        corrupt;

    int n_pass;
    int n_total;

    imem_boot_loader dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .base_addr     (base_addr),
        .word_count    (word_count),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .mem_dbg_en    (mem_dbg_en),
        .mem_dbg_addr  (mem_dbg_addr),
        .mem_dbg_data  (mem_dbg_data),
        .mem_dbg_we    (mem_dbg_we),
        .mem_dbg_rdata (mem_dbg_rdata),
        .core_hold     (core_hold),
        .busy          (busy),
        .done          (done),
        .err_code      (err_code),
        .err_addr      (err_addr),
        .words_loaded  (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial write_count = 0;
    always @(posedge clk) begin
        if (mem_dbg_en && mem_dbg_we) begin
            mem[mem_dbg_addr[11:2]] <= mem_dbg_data;
            write_count <= write_count + 1;
        end
    end

    assign mem_dbg_rdata = corrupt ? 32'h0 : mem[mem_dbg_addr[11:2]];

    typedef struct {
        logic [31:0] base;
        logic [10:0] count;
        int          stall;
        int          corrupt_at;
        bit          poke;
        logic [1:0]  exp_err;
        logic [31:0] exp_err_addr;
        bit          chk_words;
        logic [10:0] exp_words;
        bit          exp_done;
        int          exp_writes;
    } sess_t;

    sess_t sessions [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] b, input int k);
        return 32'h5A00_0000 + (b << 4) + 32'(k) + 32'd1;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_hold"},  32'(core_hold), 32'd1);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_en"},    32'(mem_dbg_en), 32'd0);
        check({tag, "_we"},    32'(mem_dbg_we), 32'd0);
        check({tag, "_data"},  mem_dbg_data, NOP_W);
        check({tag, "_addr"},  mem_dbg_addr, 32'd0);
        check({tag, "_err"},   32'(err_code), 32'd0);
        check({tag, "_eaddr"}, err_addr, 32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    task automatic run_session(input int id, input sess_t s);
        int k;
        int gap;
        int cyc;
        bit poked;
        int wc0;
        wc0 = write_count;
        base_addr  = s.base;
        word_count = s.count;
        start      = 1'b1;
        s_valid    = 1'b0;
        step();
        start = 1'b0;
        if (s.count != 11'd0)
            check($sformatf("s%0d_hold_after_start", id), 32'(core_hold), 32'd1);
        k = 0; gap = 0; cyc = 0; poked = 0;
        while (busy && cyc < 300) begin
            corrupt = (s.corrupt_at >= 0) && (k - 1 == s.corrupt_at) && !s_ready && !mem_dbg_we;
            start = s.poke && mem_dbg_we && !poked;
            if (start) begin
                base_addr = 32'h2;
                poked = 1;
            end
            if (s_ready) begin
                if (k > 0 && gap < s.stall) begin
                    s_valid = 1'b0;
                    gap++;
                    check($sformatf("s%0d_stall_we", id), 32'(mem_dbg_we), 32'd0);
                end else begin
                    s_valid = 1'b1;
                    s_data  = word_of(s.base, k);
                    k++;
                    gap = 0;
                end
            end else begin
                // Junk offered outside LOAD must never be consumed
                s_valid = (s.stall > 0);
                s_data  = 32'hBAD0_0000;
            end
            step();
            cyc++;
        end
        corrupt = 1'b0;
        s_valid = 1'b0;
        start   = 1'b0;
        check($sformatf("s%0d_timeout_busy", id), 32'(busy), 32'd0);
        check($sformatf("s%0d_err_code", id), 32'(err_code), 32'(s.exp_err));
        if (s.exp_err != 2'd0)
            check($sformatf("s%0d_err_addr", id), err_addr, s.exp_err_addr);
        check($sformatf("s%0d_done", id), 32'(done), 32'(s.exp_done));
        check($sformatf("s%0d_core_hold", id), 32'(core_hold), 32'(!s.exp_done));
        if (s.chk_words)
            check($sformatf("s%0d_words", id), 32'(words_loaded), 32'(s.exp_words));
        check($sformatf("s%0d_writes", id), 32'(write_count - wc0), 32'(s.exp_writes));
        for (int j = 0; j < s.exp_writes; j++)
            check($sformatf("s%0d_mem%0d", id, j), mem[((s.base >> 2) + 32'(j)) & 32'h3FF], word_of(s.base, j));
        $display("session %0d base=%h count=%0d -> err=%0d done=%0d words=%0d", id, s.base, s.count, err_code, done, words_loaded);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prog [4];
        logic [5:0]  exp_stat;
        sess_t       s;
        n_pass = 0; n_total = 0;
        corrupt = 1'b0;
        prog[0] = 32'h00500093; prog[1] = 32'h00108113;
        prog[2] = 32'h002081B3; prog[3] = 32'h00000013;

        //             base          cnt  stall corr poke err  err_addr     chkw words done writes
        sessions[0] = '{32'h0000_0100, 11'd3, 0, -1, 1'b1, 2'd0, 32'h0,        1'b1, 11'd3, 1'b1, 3};
        sessions[1] = '{32'h0000_0200, 11'd2, 5, -1, 1'b0, 2'd0, 32'h0,        1'b1, 11'd2, 1'b1, 2};
        sessions[2] = '{32'h0000_0002, 11'd4, 0, -1, 1'b0, 2'd3, 32'h2,        1'b0, 11'd0, 1'b0, 0};
        sessions[3] = '{32'h0000_0FFC, 11'd2, 0, -1, 1'b0, 2'd2, 32'h1000,     1'b1, 11'd1, 1'b0, 1};
        sessions[4] = '{32'h0000_0040, 11'd3, 0,  1, 1'b0, 2'd1, 32'h44,       1'b1, 11'd1, 1'b0, 2};
        sessions[5] = '{32'h0000_0040, 11'd1, 0, -1, 1'b0, 2'd0, 32'h0,        1'b1, 11'd1, 1'b1, 1};
        sessions[6] = '{32'h0000_0000, 11'd0, 0, -1, 1'b0, 2'd0, 32'h0,        1'b0, 11'd0, 1'b1, 0};
        sessions[7] = '{32'h0000_03F8, 11'd2, 0, -1, 1'b0, 2'd0, 32'h0,        1'b1, 11'd2, 1'b1, 2};

        reset_n = 1'b0; start = 1'b0; base_addr = 32'd0; word_count = 11'd0;
        s_valid = 1'b0; s_data = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset_n = 1'b1;
        step();

        // 4-word image at address 0 with s_valid held high, checked cycle by cycle
        base_addr = 32'd0; word_count = 11'd4; start = 1'b1;
        s_valid = 1'b1; s_data = prog[0];
        step();
        start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            exp_stat = {(c % 3 == 0), (c % 3 == 1), 1'b1, 1'b1, 1'b0, 1'b1};
            check($sformatf("cyc%0d_status", c),
                  32'({s_ready, mem_dbg_we, mem_dbg_en, busy, done, core_hold}), 32'(exp_stat));
            check($sformatf("cyc%0d_addr", c), mem_dbg_addr, 32'(4 * (c / 3)));
            if (c % 3 == 1)
                check($sformatf("cyc%0d_wdata", c), mem_dbg_data, prog[c / 3]);
            s_data = prog[c / 3];
            step();
        end
        s_valid = 1'b0;
        check("img_final_status", 32'({s_ready, mem_dbg_we, mem_dbg_en, busy, done, core_hold}), 32'(6'b000010));
        check("img_words", 32'(words_loaded), 32'd4);
        check("img_err", 32'(err_code), 32'd0);
        check("img_wdata_idle", mem_dbg_data, NOP_W);
        for (int j = 0; j < 4; j++)
            check($sformatf("img_mem%0d", j), mem[j], prog[j]);
        $display("image load base=0 count=4 -> done=%0d words=%0d", done, words_loaded);

        // Table of sessions
        for (int i = 0; i < 8; i++)
            run_session(i, sessions[i]);

        // Asynchronous reset in the middle of a WRITE cycle
        base_addr = 32'h80; word_count = 11'd2; start = 1'b1;
        s_valid = 1'b1; s_data = 32'h1234_5678;
        step();
        start = 1'b0;
        step();
        s_valid = 1'b0;
        check("prereset_we", 32'(mem_dbg_we), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_we_drop", 32'(mem_dbg_we), 32'd0);
        check_reset_values("midreset");
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        s = '{32'h0000_0080, 11'd2, 0, -1, 1'b0, 2'd0, 32'h0, 1'b1, 11'd2, 1'b1, 2};
        run_session(8, s);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
